// File: rtl/dmem_bram_pkg.sv
// Shared types, byte-write-enable encodings and the WRITE_FIRST lane merge
// used by dmem_bram and by the data-memory controller's bench.
package dmem_bram_pkg;

   typedef logic [31:0] word_t;

   localparam logic [3:0] WE_NONE = 4'b0000;
   localparam logic [3:0] WE_B0   = 4'b0001;
   localparam logic [3:0] WE_B1   = 4'b0010;
   localparam logic [3:0] WE_B2   = 4'b0100;
   localparam logic [3:0] WE_B3   = 4'b1000;
   localparam logic [3:0] WE_H0   = 4'b0011;
   localparam logic [3:0] WE_H1   = 4'b1100;
   localparam logic [3:0] WE_W    = 4'b1111;

   // Lanes with we set take the new byte, the rest keep the stored byte.
   function automatic word_t merge_lanes(word_t old_w, word_t din, logic [3:0] we);
      word_t res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (we[i]) res[8*i +: 8] = din[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmem_bram_if.sv
// BRAM port between the data-memory controller (master) and dmem_bram (slave).
interface dmem_bram_if;
   import dmem_bram_pkg::*;

   // bram_en qualifies a request; there is no ready, the responder accepts every
   // enabled cycle. bram_dout/bram_oor update only on enabled edges and hold otherwise.
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [31:0] bram_addr;
   word_t       bram_din;
   word_t       bram_dout;
   logic        bram_oor;

   modport master (
      output bram_en, bram_we, bram_addr, bram_din,
      input  bram_dout, bram_oor
   );

   modport slave (
      input  bram_en, bram_we, bram_addr, bram_din,
      output bram_dout, bram_oor
   );

endinterface

// File: rtl/dmem_bram_out_pipe.sv
// One- or two-stage registered read-data/oor pipeline; stages load only on
// enabled edges and are flushed by reset.
module dmem_bram_out_pipe
   import dmem_bram_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  en,
   input  word_t data,
   input  logic  oor,
   output word_t q_data,
   output logic  q_oor
);

   word_t s1_data;
   logic  s1_oor;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_data <= '0;
         s1_oor  <= 1'b0;
      end else if (en) begin
         s1_data <= data;
         s1_oor  <= oor;
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      word_t s2_data;
      logic  s2_oor;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            s2_data <= '0;
            s2_oor  <= 1'b0;
         end else if (en) begin
            s2_data <= s1_data;
            s2_oor  <= s1_oor;
         end
      end

      assign q_data = s2_data;
      assign q_oor  = s2_oor;
   end else begin : g_lat1
      assign q_data = s1_data;
      assign q_oor  = s1_oor;
   end

endmodule

// File: rtl/dmem_bram.sv
// Byte-write-enabled single-port WRITE_FIRST RAM, word addressed.
// Optional access counters when DMEM_BRAM_STATS_EN is defined.
module dmem_bram
   import dmem_bram_pkg::*;
#(
   parameter int DEPTH        = 32,
   parameter int READ_LATENCY = 1
) (
   input  logic          clk,
   input  logic          reset_n,
   dmem_bram_if.slave    bus
`ifdef DMEM_BRAM_STATS_EN
   ,
   output logic [15:0]   rd_count,
   output logic [15:0]   wr_count
`endif
);

   localparam int AW = $clog2(DEPTH);

   word_t           mem [DEPTH];
   logic [AW-1:0]   idx;
   logic            in_range;
   logic            access;
   word_t           rd_word;

   assign idx      = bus.bram_addr[AW-1:0];
   assign in_range = (bus.bram_addr[31:AW] == '0);
   assign access   = reset_n && bus.bram_en;

   // mem[idx] is the pre-edge contents, so merging din gives the WRITE_FIRST word.
   assign rd_word = in_range ? merge_lanes(mem[idx], bus.bram_din, bus.bram_we) : '0;

   always_ff @(posedge clk) begin
      if (access && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.bram_we[i]) mem[idx][8*i +: 8] <= bus.bram_din[8*i +: 8];
         end
      end
   end

   dmem_bram_out_pipe #(
      .READ_LATENCY (READ_LATENCY)
   ) u_out_pipe (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (bus.bram_en),
      .data    (rd_word),
      .oor     (!in_range),
      .q_data  (bus.bram_dout),
      .q_oor   (bus.bram_oor)
   );

`ifdef DMEM_BRAM_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_count <= '0;
         wr_count <= '0;
      end else if (bus.bram_en && in_range) begin
         if (bus.bram_we == WE_NONE) rd_count <= rd_count + 16'd1;
         else                        wr_count <= wr_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_bram.sv
// Directed bench for dmem_bram: one latency-1 and one latency-2 instance
// sharing clock and reset; stats checks only when DMEM_BRAM_STATS_EN is defined.
module tb_dmem_bram;
   import dmem_bram_pkg::*;

   logic clk;
   logic reset_n;

   dmem_bram_if bus1 ();
   dmem_bram_if bus2 ();

`ifdef DMEM_BRAM_STATS_EN
   logic [15:0] rd_count1, wr_count1, rd_count2, wr_count2;
`endif

   dmem_bram #(.DEPTH(32), .READ_LATENCY(1)) u_lat1 (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus1.slave)
`ifdef DMEM_BRAM_STATS_EN
      ,
      .rd_count (rd_count1),
      .wr_count (wr_count1)
`endif
   );

   dmem_bram #(.DEPTH(32), .READ_LATENCY(2)) u_lat2 (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus2.slave)
`ifdef DMEM_BRAM_STATS_EN
      ,
      .rd_count (rd_count2),
      .wr_count (wr_count2)
`endif
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // scoreboard: {oor, dout}
   logic [32:0] exp_q[$];

   typedef struct {
      logic        en;
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] exp_dout;
      logic        exp_oor;
   } vec_t;

   vec_t vecs[17];

   task automatic check_val(input string name, input logic [32:0] act);
      logic [32:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got oor=%0b dout=%08h, want oor=%0b dout=%08h",
                  name, act[32], act[31:0], exp[32], exp[31:0]);
      end
   endtask

   task automatic drive1(input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] din);
      bus1.bram_en   = en;
      bus1.bram_we   = we;
      bus1.bram_addr = addr;
      bus1.bram_din  = din;
   endtask

   task automatic drive2(input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic [31:0] din);
      bus2.bram_en   = en;
      bus2.bram_we   = we;
      bus2.bram_addr = addr;
      bus2.bram_din  = din;
   endtask

   // drive lat2 for one edge, then check dout/oor just after it
   task automatic step2(input string name, input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] din,
                        input logic [31:0] exp_dout, input logic exp_oor);
      drive2(en, we, addr, din);
      @(posedge clk); #1;
      exp_q.push_back({exp_oor, exp_dout});
      check_val(name, {bus2.bram_oor, bus2.bram_dout});
   endtask

   task automatic tick2(input logic en, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] din);
      drive2(en, we, addr, din);
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, WE_W,    32'd3,          32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[1]  = '{1'b1, WE_NONE, 32'd3,          32'h00000000, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, WE_W,    32'd5,          32'h11223344, 32'h11223344, 1'b0};
      vecs[3]  = '{1'b1, WE_B2,   32'd5,          32'h00AA0000, 32'h11AA3344, 1'b0};
      vecs[4]  = '{1'b1, WE_NONE, 32'd5,          32'h00000000, 32'h11AA3344, 1'b0};
      vecs[5]  = '{1'b1, WE_W,    32'd0,          32'h01234567, 32'h01234567, 1'b0};
      vecs[6]  = '{1'b1, WE_W,    32'd32,         32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[7]  = '{1'b1, WE_NONE, 32'd0,          32'h00000000, 32'h01234567, 1'b0};
      vecs[8]  = '{1'b1, WE_H0,   32'd0,          32'h0000BEEF, 32'h0123BEEF, 1'b0};
      vecs[9]  = '{1'b1, WE_H1,   32'd0,          32'hCAFE0000, 32'hCAFEBEEF, 1'b0};
      vecs[10] = '{1'b1, WE_W,    32'd31,         32'h55555555, 32'h55555555, 1'b0};
      vecs[11] = '{1'b1, WE_B0,   32'd31,         32'h000000AA, 32'h555555AA, 1'b0};
      vecs[12] = '{1'b0, WE_W,    32'd31,         32'h00000000, 32'h555555AA, 1'b0};
      vecs[13] = '{1'b1, WE_NONE, 32'd31,         32'h00000000, 32'h555555AA, 1'b0};
      vecs[14] = '{1'b1, WE_NONE, 32'h80000000,   32'h00000000, 32'h00000000, 1'b1};
      vecs[15] = '{1'b1, WE_B3,   32'd3,          32'h77000000, 32'h77ADBEEF, 1'b0};
      vecs[16] = '{1'b1, WE_B1,   32'd3,          32'h00001100, 32'h77AD11EF, 1'b0};

      reset_n = 1'b0;
      drive1(1'b0, WE_NONE, '0, '0);
      drive2(1'b0, WE_NONE, '0, '0);
      repeat (3) @(posedge clk);
      #1;
      exp_q.push_back({1'b0, 32'h0});
      check_val("reset_lat1", {bus1.bram_oor, bus1.bram_dout});
      exp_q.push_back({1'b0, 32'h0});
      check_val("reset_lat2", {bus2.bram_oor, bus2.bram_dout});
      reset_n = 1'b1;

      // latency 1 table
      for (int i = 0; i < 17; i++) begin
         drive1(vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].din);
         @(posedge clk); #1;
         exp_q.push_back({vecs[i].exp_oor, vecs[i].exp_dout});
         check_val($sformatf("lat1_vec%0d", i), {bus1.bram_oor, bus1.bram_dout});
      end
      drive1(1'b0, WE_NONE, '0, '0);

      // latency 2: pipeline, en gap, out-of-range, reset flush
      tick2(1'b1, WE_W, 32'd1, 32'h11110001);
      step2("lat2_first",  1'b1, WE_W,    32'd2,  32'h22220002, 32'h11110001, 1'b0);
      step2("lat2_w2",     1'b1, WE_NONE, 32'd1,  32'h0,        32'h22220002, 1'b0);
      step2("lat2_rd1",    1'b1, WE_NONE, 32'd2,  32'h0,        32'h11110001, 1'b0);
      step2("lat2_gap0",   1'b0, WE_NONE, 32'd7,  32'h0,        32'h11110001, 1'b0);
      step2("lat2_gap1",   1'b0, WE_W,    32'd1,  32'hFFFFFFFF, 32'h11110001, 1'b0);
      step2("lat2_gap2",   1'b0, WE_NONE, 32'd9,  32'h0,        32'h11110001, 1'b0);
      step2("lat2_rd2",    1'b1, WE_NONE, 32'd1,  32'h0,        32'h22220002, 1'b0);
      step2("lat2_pre_oor",1'b1, WE_NONE, 32'd40, 32'h0,        32'h11110001, 1'b0);
      step2("lat2_oor",    1'b1, WE_NONE, 32'd2,  32'h0,        32'h00000000, 1'b1);
      step2("lat2_inflt",  1'b1, WE_NONE, 32'd1,  32'h0,        32'h22220002, 1'b0);
      reset_n = 1'b0;
      step2("lat2_rst",    1'b1, WE_W,    32'd1,  32'hFFFFFFFF, 32'h00000000, 1'b0);
      reset_n = 1'b1;
      step2("lat2_flush",  1'b1, WE_NONE, 32'd1,  32'h0,        32'h00000000, 1'b0);
      step2("lat2_nowr",   1'b1, WE_NONE, 32'd1,  32'h0,        32'h11110001, 1'b0);
      drive2(1'b0, WE_NONE, '0, '0);

`ifdef DMEM_BRAM_STATS_EN
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      drive1(1'b1, WE_W, 32'd4, 32'hA5A5A5A5);
      repeat (65535) @(posedge clk);
      #1;
      drive1(1'b0, WE_NONE, '0, '0);
      exp_q.push_back({1'b0, 16'h0000, 16'hFFFF});
      check_val("stats_wr_preset", {1'b0, rd_count1, wr_count1});
      drive1(1'b1, WE_B0, 32'd4, 32'h0000005A);
      @(posedge clk); #1;
      drive1(1'b1, WE_NONE, 32'd33, 32'h0);
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         drive1(1'b1, WE_NONE, 32'd4, 32'h0);
         @(posedge clk); #1;
      end
      drive1(1'b0, WE_NONE, '0, '0);
      exp_q.push_back({1'b0, 16'h0003, 16'h0000});
      check_val("stats_wrap", {1'b0, rd_count1, wr_count1});
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dmem_bram.md
# dmem_bram

Synchronous, byte-write-enabled single-port RAM that services the data-memory controller's BRAM interface (address, write data, 4-bit byte write enable, enable, read data). It is the responder end of that interface and replaces the vendor BRAM IP in simulation and in IP-free builds. It implements WRITE_FIRST semantics with 1- or 2-cycle read latency. Word-addressed; the controller has already converted byte addresses and aligned the store lanes.

## Interface
- DEPTH, 32: number of 32-bit words; must be a power of two, 2..1024.
- READ_LATENCY, 1: cycles from address sample to `bram_dout`; legal values 1 or 2.
- clk  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- bram_en  input  1  access enable; when 0, no read, no write, pipeline holds.
- bram_we  input  4  byte write enables; bit i writes `bram_din[8i+7:8i]`.
- bram_addr  input  32  word address; only bits [$clog2(DEPTH)-1:0] index storage.
- bram_din  input  32  write data, already lane-aligned by the initiator.
- bram_dout  output  32  read data, WRITE_FIRST.
- bram_oor  output  1  out-of-range flag, aligned with `bram_dout`.

## Operation
- Access cycle: rising edge with reset_n=1 and bram_en=1.
- Range: address in range iff bram_addr[31:$clog2(DEPTH)] == 0. Out-of-range access: no storage change; read word forced to 0; oor bit 1.
- Write: each lane with bram_we[i]=1 is stored; lanes with we[i]=0 keep their old value.
- Read word (stage 1): for each lane, new din byte if we[i]=1, else the stored byte before the edge (WRITE_FIRST merge). we=0 is a pure read.
- READ_LATENCY=1: stage-1 register drives bram_dout/bram_oor.
- READ_LATENCY=2: a second register copies stage 1; both stages load only on access cycles (bram_en=1), otherwise hold.
- bram_en=0: storage, pipeline, and outputs all hold.
- Storage contents are not cleared by reset (BRAM behaviour); initial contents are 0 at time zero.
- Reset: stage registers, bram_dout, and bram_oor go to 0. An access presented in a reset cycle is discarded, including its write.
- Reset during a 2-cycle read: both stages are flushed. The in-flight word is lost; the initiator must re-issue.

## Timing
- Address, din, we, and en are sampled at edge N.
- Latency 1: merged word visible on bram_dout after edge N, valid through the next access edge.
- Latency 2: visible after edge N+1, provided en=1 at N+1.
- Back-to-back accesses: one per cycle, no bubbles.
- Read-after-write, same address, next cycle: returns the written bytes (no bypass needed; storage is already updated).
- No combinational path from any input to any output.

## Configuration
- DMEM_BRAM_STATS_EN defined:
  - Adds outputs `rd_count` (16) and `wr_count` (16).
  - Each in-range access with we==0 increments rd_count; we!=0 increments wr_count.
  - Counters wrap 0xFFFF -> 0x0000; out-of-range accesses are not counted; both reset to 0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

## Structure
- Package dmem_bram_pkg: WE_NONE/WE_B0..WE_B3/WE_H0/WE_H1/WE_W constants, word_t typedef (32-bit), and `merge_lanes(old, din, we)` function shared with the controller's test bench.
- Sub-module dmem_bram_out_pipe: the 1/2-stage data+oor output pipeline, selected by READ_LATENCY, with en-gated load and reset flush.

## Test plan
- Latency 1: write 0xDEADBEEF to word 3 with we=4'hF, then read word 3 -> dout 0xDEADBEEF one cycle after the read edge; oor=0.
- Byte merge: word 5=0x11223344, then write we=4'b0100 din=0x00AA0000 -> same-cycle WRITE_FIRST dout 0x11AA3344, and a later read returns 0x11AA3344.
- Out of range: DEPTH=32, addr=32, we=4'hF, din=0xFFFFFFFF -> dout 0, oor=1; a read of word 0 afterwards is unchanged.
- Latency 2 with en gap: reads of words 1, 2, then en=0 for 3 cycles -> dout shows word 1 at N+1, word 2 only after the next en=1 edge, and holds during the gap.
- Reset mid-read (latency 2): reset_n=0 one cycle after the read edge -> dout=0, oor=0; a write presented during reset does not change memory.
- DMEM_BRAM_STATS_EN: wr_count preset by 65535 writes, then 1 write plus 3 reads -> wr_count 0x0000, rd_count 3.
